// File: rtl/cam_soc_nios2_debug_cmd_initiator.sv
// Command-issuing side of the Nios II debug-slave IR/DR protocol (system clock domain).
// Optional IR caching that skips redundant update-IR cycles is enabled by DBG_IR_CACHE_EN.
module cam_soc_nios2_debug_cmd_initiator #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_ir,
  input  logic [37:0] cmd_data,
  input  logic        cmd_wait,
  output logic [1:0]  ir_in,
  output logic [37:0] sr,
  output logic        vs_uir,
  output logic        vs_udr,
  input  logic        monitor_ready,
  input  logic        monitor_error,
  input  logic [31:0] MonDReg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        rsp_timeout
);

  localparam int unsigned SetW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned WaitW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SetW-1:0]  SetLast  = SetW'(SETTLE_CYC - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StUir, StSettle, StUdr, StWait, StRsp} state_e;

  state_e            state_q, state_d;
  logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              wait_flag_q, wait_flag_d;
  logic [1:0]        ir_in_q, ir_in_d;
  logic [37:0]       sr_q, sr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              vs_uir_q, vs_uir_d;
  logic              vs_udr_q, vs_udr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_timeout_q, rsp_timeout_d;
`ifdef DBG_IR_CACHE_EN
  logic              ir_valid_q, ir_valid_d;
`endif

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    wait_flag_d   = wait_flag_q;
    ir_in_d       = ir_in_q;
    sr_d          = sr_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef DBG_IR_CACHE_EN
    ir_valid_d    = ir_valid_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          ir_in_d      = cmd_ir;
          sr_d         = cmd_data;
          wait_flag_d  = cmd_wait;
          settle_cnt_d = '0;
          state_d      = StUir;
`ifdef DBG_IR_CACHE_EN
          // ir_in_q still holds the IR last sent to the slave; a match skips update-IR.
          if (ir_valid_q && (cmd_ir == ir_in_q)) state_d = StSettle;
          ir_valid_d = 1'b1;
`endif
        end
      end
      StUir: begin
        settle_cnt_d = '0;
        state_d      = StSettle;
      end
      StSettle: begin
        if (settle_cnt_q == SetLast) begin
          state_d = StUdr;
        end else if (settle_cnt_q != '1) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StUdr: begin
        wait_cnt_d = '0;
        if (wait_flag_q) begin
          state_d = StWait;
        end else begin
          rsp_data_d    = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end
      end
      StWait: begin
        // Ready takes priority over a timeout expiring in the same cycle.
        if (monitor_ready) begin
          rsp_data_d    = MonDReg;
          rsp_error_d   = monitor_error;
          rsp_timeout_d = 1'b0;
          state_d       = StRsp;
        end else if ((TIMEOUT_CYC != 0) && (wait_cnt_q == WaitLast)) begin
          rsp_data_d    = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StRsp;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    vs_uir_d    = (state_d == StUir);
    vs_udr_d    = (state_d == StUdr);
    rsp_valid_d = (state_d == StRsp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      wait_flag_q   <= 1'b0;
      ir_in_q       <= '0;
      sr_q          <= '0;
      cmd_ready_q   <= 1'b1;
      vs_uir_q      <= 1'b0;
      vs_udr_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
`ifdef DBG_IR_CACHE_EN
      ir_valid_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      wait_flag_q   <= wait_flag_d;
      ir_in_q       <= ir_in_d;
      sr_q          <= sr_d;
      cmd_ready_q   <= cmd_ready_d;
      vs_uir_q      <= vs_uir_d;
      vs_udr_q      <= vs_udr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef DBG_IR_CACHE_EN
      ir_valid_q    <= ir_valid_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign ir_in       = ir_in_q;
  assign sr          = sr_q;
  assign vs_uir      = vs_uir_q;
  assign vs_udr      = vs_udr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cam_soc_nios2_debug_cmd_initiator.sv
// Directed bench: instance A (SETTLE_CYC=4, TIMEOUT_CYC=1024) and B (SETTLE_CYC=4, TIMEOUT_CYC=8).
module tb_cam_soc_nios2_debug_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        cmd_wait;
  logic        monitor_ready, monitor_error;
  logic [31:0] mon_dreg;

  logic        a_cmd_valid, a_cmd_ready, a_vs_uir, a_vs_udr, a_rsp_valid, a_rsp_ready;
  logic        a_rsp_error, a_rsp_timeout;
  logic [1:0]  a_ir_in;
  logic [37:0] a_sr;
  logic [31:0] a_rsp_data;

  logic        b_cmd_valid, b_cmd_ready, b_vs_uir, b_vs_udr, b_rsp_valid, b_rsp_ready;
  logic        b_rsp_error, b_rsp_timeout;
  logic [1:0]  b_ir_in;
  logic [37:0] b_sr;
  logic [31:0] b_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int uir_cnt = 0, udr_cnt = 0, both_cnt = 0;
  int uir_cyc = -1, udr_cyc = -1;

  always #5 clk = ~clk;

  cam_soc_nios2_debug_cmd_initiator #(.SETTLE_CYC(4), .TIMEOUT_CYC(1024)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_wait(cmd_wait), .ir_in(a_ir_in), .sr(a_sr),
    .vs_uir(a_vs_uir), .vs_udr(a_vs_udr), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .MonDReg(mon_dreg), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_error(a_rsp_error),
    .rsp_timeout(a_rsp_timeout)
  );

  cam_soc_nios2_debug_cmd_initiator #(.SETTLE_CYC(4), .TIMEOUT_CYC(8)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_wait(cmd_wait), .ir_in(b_ir_in), .sr(b_sr),
    .vs_uir(b_vs_uir), .vs_udr(b_vs_udr), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .MonDReg(mon_dreg), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_error(b_rsp_error),
    .rsp_timeout(b_rsp_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log A's strobes.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (a_vs_uir) begin uir_cnt++; uir_cyc = cyc; end
    if (a_vs_udr) begin udr_cnt++; udr_cyc = cyc; end
    if (a_vs_uir && a_vs_udr) both_cnt++;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return a_vs_udr;
      1:       return a_rsp_valid;
      2:       return b_vs_udr;
      default: return b_rsp_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag, output int at);
    int n = 0;
    while (!probe(which) && n < 3000) begin tick(); n++; end
    check(tag, probe(which), 1'b1);
    at = cyc;
  endtask

  // Offer a command at this falling edge; acc + k is then spec cycle T+k.
  task automatic issue(input bit to_b, input logic [1:0] ir, input logic [37:0] data,
                       input logic w, output int acc);
    cmd_ir = ir; cmd_data = data; cmd_wait = w;
    if (to_b) b_cmd_valid = 1'b1; else a_cmd_valid = 1'b1;
    acc = cyc;
    tick();
    a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
  endtask

  task automatic handshake(input bit to_b);
    if (to_b) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
  endtask

  initial begin
    int acc, at, u, n0, b_udr;
    logic stable;
    reset_n = 1'b0;
    a_cmd_valid = 1'b0; b_cmd_valid = 1'b0; a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    cmd_ir = '0; cmd_data = '0; cmd_wait = 1'b0;
    monitor_ready = 1'b0; monitor_error = 1'b0; mon_dreg = '0;
    tick(); tick();
    check("rst_cmd_ready", a_cmd_ready, 1'b1);
    check("rst_vs_uir", a_vs_uir, 1'b0);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_sr", a_sr, 38'h0);
    check("rst_ir_in", a_ir_in, 2'b00);
    reset_n = 1'b1;
    tick();

    // 1: no-wait command
    issue(1'b0, 2'b10, 38'h15_5555_5555, 1'b0, acc);
    check("t1_uir_at_T1", a_vs_uir, 1'b1);
    check("t1_cmd_ready_low", a_cmd_ready, 1'b0);
    check("t1_ir_in", a_ir_in, 2'b10);
    wait_for(1, "t1_rsp_seen", at);
    check("t1_uir_cyc", uir_cyc - acc, 1);
    check("t1_udr_cyc", udr_cyc - acc, 6);
    check("t1_rsp_cyc", at - acc, 7);
    check("t1_rsp_data", a_rsp_data, 32'h0);
    check("t1_rsp_timeout", a_rsp_timeout, 1'b0);
    check("t1_sr_stable", a_sr, 38'h15_5555_5555);
    handshake(1'b0);
    check("t1_cmd_ready_back", a_cmd_ready, 1'b1);

    // 2: wait for monitor_ready 10 cycles after vs_udr; 4: back-pressure the response
    mon_dreg = 32'hDEAD_BEEF; monitor_error = 1'b0;
    issue(1'b0, 2'b00, 38'h0_0000_1234, 1'b1, acc);
    wait_for(0, "t2_udr_seen", u);
    check("t2_udr_cyc", u - acc, 6);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (a_rsp_valid) stable = 1'b0;
      tick();
    end
    check("t2_no_early_rsp", stable, 1'b1);
    monitor_ready = 1'b1;
    tick();
    monitor_ready = 1'b0;
    check("t2_rsp_cyc", a_rsp_valid, 1'b1);
    check("t2_rsp_data", a_rsp_data, 32'hDEAD_BEEF);
    check("t2_rsp_timeout", a_rsp_timeout, 1'b0);
    check("t2_rsp_error", a_rsp_error, 1'b0);
    mon_dreg = 32'h1111_2222;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!a_rsp_valid || a_cmd_ready || a_rsp_data !== 32'hDEAD_BEEF) stable = 1'b0;
    end
    check("t4_hold_stable", stable, 1'b1);
    handshake(1'b0);
    check("t4_cmd_ready_next", a_cmd_ready, 1'b1);
    check("t4_rsp_dropped", a_rsp_valid, 1'b0);

    // Ready present on the first WAIT cycle, with error
    monitor_error = 1'b1;
    issue(1'b0, 2'b00, 38'h0_0000_0042, 1'b1, acc);
    wait_for(0, "tw_udr_seen", u);
    monitor_ready = 1'b1;
    tick();
    wait_for(1, "tw_rsp_seen", at);
    monitor_ready = 1'b0; monitor_error = 1'b0;
    check("tw_rsp_cyc", at - u, 2);
    check("tw_rsp_error", a_rsp_error, 1'b1);
    check("tw_rsp_data", a_rsp_data, 32'h1111_2222);
    handshake(1'b0);

    // 3: timeout on instance B
    issue(1'b1, 2'b11, 38'h2A_0000_0001, 1'b1, acc);
    check("t3_b_uir", b_vs_uir, 1'b1);
    wait_for(2, "t3_udr_seen", b_udr);
    wait_for(3, "t3_rsp_seen", at);
    check("t3_rsp_cyc", at - b_udr, 9);
    check("t3_rsp_timeout", b_rsp_timeout, 1'b1);
    check("t3_rsp_data", b_rsp_data, 32'h0);
    check("t3_rsp_error", b_rsp_error, 1'b0);
    handshake(1'b1);
    check("t3_cmd_ready_back", b_cmd_ready, 1'b1);

    // 5: reset during SETTLE
    issue(1'b0, 2'b10, 38'h3F_FFFF_FFFF, 1'b0, acc);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("t5_cmd_ready", a_cmd_ready, 1'b1);
    check("t5_sr_cleared", a_sr, 38'h0);
    check("t5_ir_cleared", a_ir_in, 2'b00);
    check("t5_vs_udr", a_vs_udr, 1'b0);
    tick();
    reset_n = 1'b1;
    n0 = udr_cnt;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (a_rsp_valid) stable = 1'b0;
    end
    check("t5_no_udr_after", udr_cnt - n0, 0);
    check("t5_no_rsp_after", stable, 1'b1);

    // 6: back-to-back same IR
    issue(1'b0, 2'b01, 38'h0_0000_0010, 1'b0, acc);
    wait_for(1, "t6_rsp1", at);
    check("t6_first_udr", udr_cyc - acc, 6);
    handshake(1'b0);
    n0 = uir_cnt;
    issue(1'b0, 2'b01, 38'h0_0000_0020, 1'b0, acc);
    wait_for(1, "t6_rsp2", at);
`ifdef DBG_IR_CACHE_EN
    check("t6_hit_no_uir", uir_cnt - n0, 0);
    check("t6_hit_udr_cyc", udr_cyc - acc, 5);
`else
    check("t6_uir_again", uir_cnt - n0, 1);
    check("t6_udr_cyc", udr_cyc - acc, 6);
`endif
    handshake(1'b0);

    check("strobes_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
